// File: rtl/output_ctrl_gen_if.sv
// Comparator-side and board-side signals of the output command generator.
interface output_ctrl_gen_if;
  logic       cmpOk;
  logic       relayReq;
  logic       relayFb;
  logic       switchCtrl1;
  logic       switchCtrl2;
  logic       relayCtrl1;
  logic       relayCtrl2;
  logic       fault;
  logic [1:0] faultCause;
  logic [1:0] state;

  // master drives the verdict/request/readback, slave is the generator
  modport master (
    output cmpOk, relayReq, relayFb,
    input  switchCtrl1, switchCtrl2, relayCtrl1, relayCtrl2, fault, faultCause, state
  );
  modport slave (
    input  cmpOk, relayReq, relayFb,
    output switchCtrl1, switchCtrl2, relayCtrl1, relayCtrl2, fault, faultCause, state
  );
endinterface

// File: rtl/output_ctrl_gen.sv
// Dual-channel output command generator: heartbeat pair + complementary relay
// command pair, dropping to a latched safe state on comparator loss or on a
// relay readback that does not follow the command.
module output_ctrl_gen #(
  parameter int HALF_PERIOD = 8,
  parameter int OK_FILTER   = 4,
  parameter int FB_TIMEOUT  = 6
) (
  input logic              clk,
  input logic              rst,
  output_ctrl_gen_if.slave bus
);
  typedef enum logic [1:0] {SAFE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_e;

  localparam logic [3:0] OK_LAST = 4'(OK_FILTER - 1);
  localparam logic [3:0] PH_LAST = 4'(HALF_PERIOD - 1);
  localparam logic [3:0] MM_MAX  = 4'(FB_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] ok_cnt_q, ok_cnt_d;
  logic [3:0] phase_cnt_q, phase_cnt_d;
  logic [3:0] mm_cnt_q, mm_cnt_d;
  logic [1:0] rc_dly_q, rc_dly_d;
  logic       fb_meta_q, fb_sync_q;
  logic       sw1_q, sw1_d, sw2_q, sw2_d;
  logic       rc1_q, rc1_d;
  logic       fault_q, fault_d;
  logic [1:0] cause_q, cause_d;

  logic       ok_done, mm_mis, mm_hit, run_fault;
  logic [3:0] mm_inc;

  // The readback is compared against relayCtrl1 delayed by the same two
  // stages as the synchronizer, so mmCnt only counts cycles in which a
  // correctly following relay would already be visible on fbSync.
  assign ok_done   = bus.cmpOk && (ok_cnt_q == OK_LAST);
  assign mm_mis    = fb_sync_q != rc_dly_q[1];
  assign mm_inc    = (mm_cnt_q == MM_MAX) ? MM_MAX : mm_cnt_q + 4'd1;
  assign mm_hit    = mm_mis && (mm_inc == MM_MAX);
  assign run_fault = !bus.cmpOk || mm_hit;

  // Two-flop synchronizer for the asynchronous relay readback
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_meta_q <= 1'b0;
      fb_sync_q <= 1'b0;
    end else begin
      fb_meta_q <= bus.relayFb;
      fb_sync_q <= fb_meta_q;
    end
  end

  // State and datapath registers; rst wins over any transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SAFE;
      ok_cnt_q    <= '0;
      phase_cnt_q <= '0;
      mm_cnt_q    <= '0;
      rc_dly_q    <= '0;
      sw1_q       <= 1'b0;
      sw2_q       <= 1'b1;
      rc1_q       <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= '0;
    end else begin
      state_q     <= state_d;
      ok_cnt_q    <= ok_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      mm_cnt_q    <= mm_cnt_d;
      rc_dly_q    <= rc_dly_d;
      sw1_q       <= sw1_d;
      sw2_q       <= sw2_d;
      rc1_q       <= rc1_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  // Next-state: filtered entry into RUN, any fault condition latches FAULT
  always_comb begin
    state_d = state_q;
    case (state_q)
      SAFE:    if (ok_done) state_d = RUN;
      RUN:     if (run_fault) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = SAFE;
    endcase
  end

  // Counters and registered outputs for each state
  always_comb begin
    ok_cnt_d    = ok_cnt_q;
    phase_cnt_d = phase_cnt_q;
    mm_cnt_d    = mm_cnt_q;
    rc_dly_d    = rc_dly_q;
    sw1_d       = sw1_q;
    rc1_d       = rc1_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    case (state_q)
      SAFE: begin
        ok_cnt_d    = (bus.cmpOk && !ok_done) ? ok_cnt_q + 4'd1 : 4'd0;
        phase_cnt_d = '0;
        mm_cnt_d    = '0;
        rc_dly_d    = '0;
        sw1_d       = 1'b0;
        rc1_d       = 1'b0;
      end
      RUN: begin
        if (run_fault) begin
          sw1_d   = 1'b0;
          rc1_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = cause_q | {mm_hit, !bus.cmpOk};
        end else begin
          if (phase_cnt_q == PH_LAST) begin
            phase_cnt_d = '0;
            sw1_d       = ~sw1_q;
          end else begin
            phase_cnt_d = phase_cnt_q + 4'd1;
          end
          rc1_d    = bus.relayReq;
          rc_dly_d = {rc_dly_q[0], rc1_q};
          mm_cnt_d = mm_mis ? mm_inc : 4'd0;
        end
      end
      default: begin
        sw1_d   = 1'b0;
        rc1_d   = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // Heartbeat line 2 is its own flop so both lines are true register outputs
  always_comb begin
    sw2_d = ~sw1_d;
  end

  assign bus.switchCtrl1 = sw1_q;
  assign bus.switchCtrl2 = sw2_q;
  assign bus.relayCtrl1  = rc1_q;
  assign bus.relayCtrl2  = 1'b0;
  assign bus.fault       = fault_q;
  assign bus.faultCause  = cause_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_output_ctrl_gen.sv
// Bench for output_ctrl_gen: directed scenarios plus randomized episodes,
// every cycle compared against a history-based reference model.
module tb_output_ctrl_gen;
  localparam int HP = 8, OKF = 4, FBT = 6, HMAX = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_ctrl_gen_if bus();

  output_ctrl_gen #(.HALF_PERIOD(HP), .OK_FILTER(OKF), .FB_TIMEOUT(FBT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk = 0, n_fail = 0;

  // reference model: edge index since reset plus input histories
  int       n, st, tr, ones, mmrun;
  bit [1:0] cause;
  bit       ok_h [HMAX];
  bit       req_h[HMAX];
  bit       fb_h [HMAX];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit ok, input bit rq, input bit fb);
    bit       fbs, ctl;
    bit [1:0] c;
    if (r || n >= HMAX - 1) begin
      n = 0; st = 0; tr = 0; ones = 0; mmrun = 0; cause = 0;
      fb_h[0] = 0; req_h[0] = 0; ok_h[0] = 0;
      return;
    end
    n++;
    ok_h[n] = ok; req_h[n] = rq; fb_h[n] = fb;
    case (st)
      0: begin
        if (ok) begin
          ones++;
          if (ones == OKF) begin st = 1; tr = n; mmrun = 0; end
        end else ones = 0;
      end
      1: begin
        // readback seen at edge n was sampled two edges earlier; the command
        // it is judged against is the one issued three edges earlier
        fbs = (n >= 2) ? fb_h[n-2] : 1'b0;
        ctl = (n - 3 <= tr) ? 1'b0 : req_h[n-3];
        mmrun = (fbs != ctl) ? mmrun + 1 : 0;
        c = {mmrun >= FBT, !ok};
        if (c != 0) begin st = 2; cause = c; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [8:0] exp_vec();
    bit s1, r1;
    case (st)
      0: return {2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      1: begin
        s1 = (((n - tr) / HP) % 2) == 1;
        r1 = (n == tr) ? 1'b0 : req_h[n];
        return {2'd1, 2'b00, 1'b0, 1'b0, r1, ~s1, s1};
      end
      default: return {2'd2, cause, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    endcase
  endfunction

  function automatic logic [8:0] got_vec();
    return {bus.state, bus.faultCause, bus.fault, bus.relayCtrl2, bus.relayCtrl1,
            bus.switchCtrl2, bus.switchCtrl1};
  endfunction

  // one clock: drive on negedge, sample 1 time unit after the active edge
  task automatic step(input bit r, input bit ok, input bit rq, input bit fb);
    @(negedge clk);
    rst = r; bus.cmpOk = ok; bus.relayReq = rq; bus.relayFb = fb;
    @(posedge clk);
    #1;
    model(r, ok, rq, fb);
    chk("cycle", 16'(got_vec()), 16'(exp_vec()));
  endtask

  task automatic to_run();
    step(1, 0, 0, 0);
    for (int e = 1; e <= OKF; e++) step(0, 1, 0, 0);
  endtask

  initial begin
    logic [7:0] pat;
    bit rq, ok, fb, r;
    int lag, okpct;
    bit rqh[$];

    // reset state and basic heartbeat timing
    step(1, 0, 0, 0);
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_sw", 16'({bus.switchCtrl1, bus.switchCtrl2}), 16'b01);
    chk("rst_rly", 16'({bus.relayCtrl1, bus.relayCtrl2}), 16'd0);
    chk("rst_flt", 16'({bus.fault, bus.faultCause}), 16'd0);
    for (int e = 1; e <= 28; e++) begin
      step(0, 1, 0, 0);
      if (e == 3)  chk("a_safe3", 16'(bus.state), 16'd0);
      if (e == 4)  chk("a_run4", 16'(bus.state), 16'd1);
      if (e == 11) chk("a_hb11", 16'({bus.switchCtrl1, bus.switchCtrl2}), 16'b01);
      if (e == 12) chk("a_hb12", 16'({bus.switchCtrl1, bus.switchCtrl2}), 16'b10);
      if (e == 20) chk("a_hb20", 16'({bus.switchCtrl1, bus.switchCtrl2}), 16'b01);
      if (e == 28) chk("a_hb28", 16'({bus.switchCtrl1, bus.switchCtrl2}), 16'b10);
    end

    // glitch in the OK filter restarts the count
    pat = 8'b1111_0111;
    step(1, 0, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      step(0, (e <= 8) ? pat[e-1] : 1'b1, 0, 0);
      if (e == 7)  chk("b_safe7", 16'(bus.state), 16'd0);
      if (e == 8)  chk("b_run8", 16'(bus.state), 16'd1);
      if (e == 15) chk("b_hb15", 16'(bus.switchCtrl1), 16'd0);
      if (e == 16) chk("b_hb16", 16'(bus.switchCtrl1), 16'd1);
    end

    // relay readback following three cycles later stays within tolerance
    for (int c = 1; c <= 20; c++) begin
      step(0, 1, 1, c >= 4);
      if (c == 1) chk("c_rly", 16'({bus.relayCtrl1, bus.relayCtrl2}), 16'b10);
    end
    chk("c_nofault", 16'({bus.state, bus.fault}), 16'({2'd1, 1'b0}));

    // readback stuck low: timeout fault at the ninth edge
    to_run();
    for (int c = 1; c <= 9; c++) begin
      step(0, 1, 1, 0);
      if (c == 8) chk("d_run8", 16'(bus.state), 16'd1);
      if (c == 9) begin
        chk("d_state", 16'(bus.state), 16'd2);
        chk("d_cause", 16'({bus.fault, bus.faultCause}), 16'b110);
        chk("d_safe", 16'({bus.relayCtrl1, bus.switchCtrl1, bus.switchCtrl2}), 16'b001);
      end
    end

    // comparator loss: latched for 50 cycles whatever the inputs, rst clears
    to_run();
    for (int c = 0; c < 3; c++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("e_cause", 16'({bus.state, bus.fault, bus.faultCause}), 16'({2'd2, 1'b1, 2'b01}));
    for (int c = 0; c < 50; c++) step(0, 1, 1'($urandom), 1'($urandom));
    chk("e_hold", 16'({bus.state, bus.switchCtrl1, bus.switchCtrl2}), 16'({2'd2, 2'b01}));
    step(1, 1, 0, 0);
    chk("e_rst", 16'(got_vec()), 16'({2'd0, 2'b00, 3'b000, 2'b10}));

    // both causes in the same cycle, then rst on that same cycle instead
    to_run();
    for (int c = 1; c <= 9; c++) step(0, c != 9, 1, 0);
    chk("f_both", 16'(bus.faultCause), 16'b11);
    to_run();
    for (int c = 1; c <= 8; c++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("f_rstwin", 16'({bus.state, bus.fault}), 16'd0);

    // randomized episodes against the reference model
    for (int ep = 0; ep < 40; ep++) begin
      step(1, 0, 0, 0);
      lag = $urandom_range(0, 9);
      okpct = (ep % 3 == 0) ? 95 : ((ep % 3 == 1) ? 99 : 100);
      rq = 0;
      rqh.delete();
      for (int c = 0; c < 150; c++) begin
        ok = $urandom_range(0, 99) < okpct;
        if ($urandom_range(0, 19) == 0) rq = ~rq;
        rqh.push_front(rq);
        if (rqh.size() > 12) void'(rqh.pop_back());
        fb = (rqh.size() > lag) ? rqh[lag] : 1'b0;
        r = $urandom_range(0, 199) == 0;
        step(r, ok, rq, fb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/output_ctrl_gen.md
# output_ctrl_gen

Dual-channel output command generator for the bus comparator. It turns the comparator verdict into the dynamic switch heartbeat pair and the complementary relay command pair that drive the output board's power-switch and relay enables. The board-side output unit only enables the switch while both heartbeat lines keep toggling, and only enables the relay while the two relay lines differ. Any comparator disagreement or relay-readback mismatch therefore drops the block to a latched safe state.

## Interface
Parameters:
- HALF_PERIOD, 8: cycles between heartbeat toggles; legal range 2..14, which keeps edges inside the board unit's 15-cycle window.
- OK_FILTER, 4: consecutive cmpOk=1 cycles required before heartbeat starts; legal range 1..15.
- FB_TIMEOUT, 6: consecutive relay-readback mismatch cycles that raise a fault; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high, on clock clk.
- cmpOk  input  1  comparator verdict; 1 = both channels agree. Synchronous to clk.
- relayReq  input  1  requested relay state; 1 = energise. Synchronous to clk.
- relayFb  input  1  relay contact readback from the output board; asynchronous.
- switchCtrl1  output  1  heartbeat line, channel 1.
- switchCtrl2  output  1  heartbeat line, channel 2; always the complement of switchCtrl1.
- relayCtrl1  output  1  relay command, channel 1.
- relayCtrl2  output  1  relay command, channel 2; held at 0.
- fault  output  1  latched fault flag.
- faultCause  output  2  bit0 = comparator loss, bit1 = readback timeout; sticky.
- state  output  2  SAFE=0, RUN=1, FAULT=2; 3 is never driven.

## Operation
- All outputs are registered.
- Reset values: switchCtrl1=0, switchCtrl2=1, relayCtrl1=0, relayCtrl2=0, fault=0, faultCause=0, state=SAFE. All counters and the synchronizer are cleared.
- relayFb passes through a 2-flop synchronizer, reset to 0. Its output is fbSync.
- SAFE state:
  - Heartbeat is static; relay lines are 00, so the relay is disabled.
  - okCnt increments while cmpOk=1 and clears to 0 on any cmpOk=0.
  - When cmpOk=1 and okCnt==OK_FILTER-1, the next state is RUN. phaseCnt and mmCnt clear on entry.
- RUN state:
  - phaseCnt counts 0..HALF_PERIOD-1 and wraps.
  - When phaseCnt==HALF_PERIOD-1, both switchCtrl lines invert at the next edge.
  - relayCtrl1 <= relayReq every cycle.
  - mmCnt increments while fbSync != relayCtrl1, saturating at FB_TIMEOUT, and clears on match.
  - cmpOk=0 sets faultCause[0]. mmCnt reaching FB_TIMEOUT sets faultCause[1].
  - Either condition moves the state to FAULT at the next edge. If both occur in the same cycle, both cause bits are set.
- FAULT state:
  - switchCtrl1=0, switchCtrl2=1, relayCtrl1=0, fault=1; all are forced at the FAULT-entry edge.
  - cmpOk, relayReq and relayFb are ignored.
  - The only exit is rst.
- Counter widths are 4 bits, so no counter can overflow within the legal parameter ranges.

## Timing
- cmpOk rising at cycle 0 and held high: state=RUN is visible at edge OK_FILTER.
- First heartbeat edge: HALF_PERIOD cycles after state becomes RUN. Subsequent edges follow every HALF_PERIOD cycles.
- relayReq to relayCtrl1 latency: 1 cycle, in RUN only.
- relayFb to fbSync latency: 2 cycles.
- FB_TIMEOUT counts cycles after synchronization, so effective readback tolerance is FB_TIMEOUT+2 cycles after a relayCtrl1 change.
- cmpOk=0 in RUN: fault=1, state=FAULT, and safe outputs appear at the next edge (1-cycle latency).
- rst has priority over every transition, including the same cycle as fault detection. rst mid-RUN returns all outputs to reset values at the next edge.
- cmpOk glitching low in SAFE restarts the OK_FILTER count from 0.

## Test plan
- Reset, then cmpOk=1 from cycle 0 with defaults -> state=RUN at edge 4; switchCtrl1 0→1 and switchCtrl2 1→0 at edge 12; next toggles at edges 20 and 28.
- cmpOk pattern 1,1,1,0,1,1,1,1 -> RUN only at edge 8; no heartbeat edges before edge 16.
- In RUN, set relayReq=1 and drive relayFb=1 three cycles later -> relayCtrl1=1 after 1 cycle, relayCtrl2=0, mmCnt never reaches 6, no fault.
- In RUN, set relayReq=1 with relayFb held 0 -> fault=1, faultCause=2'b10, relayCtrl1=0, heartbeat frozen at 0/1, state=FAULT at edge 9 after the relayReq change.
- In RUN, drop cmpOk for 1 cycle, then restore it -> fault=1 and faultCause=2'b01 at the next edge; state stays FAULT with outputs safe for 50 cycles; rst then returns all outputs to reset values.
- Align cmpOk=0 with the mmCnt-saturate cycle -> faultCause=2'b11. Apply rst in the same cycle instead -> state=SAFE, fault=0.
